pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter PC_W, 8, program-counter and address width in bits.
REQ-002 SHALL have parameter STACK_D, 4, return-stack depth in entries, a power of two.
REQ-003 SHALL have port clk_i  input  1  the single core clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset, sampled on the clk_i rising edge.
REQ-005 SHALL have port mode_pc_i  input  modePC  next-PC mode from the decoder: INCREMENT, RELATIVE, SUBROUTINE or RETURN.
REQ-006 SHALL have port offset_i  input  PC_W  two's-complement branch offset used by RELATIVE.
REQ-007 SHALL have port target_i  input  PC_W  absolute call target used by SUBROUTINE.
REQ-008 SHALL have port halt_core_i  input  1  halt request from the decoder.
REQ-009 SHALL have port wfi_core_i  input  1  wait-for-interrupt request from the decoder.
REQ-010 SHALL have port ext_int_i  input  1  external interrupt, level-sensitive.
REQ-011 SHALL have port pc_o  output  PC_W  current instruction address, registered.
REQ-012 SHALL have port halted_o  output  1  core is in HALTED.
REQ-013 SHALL have port waiting_o  output  1  core is in WAIT.
REQ-014 SHALL have port stk_ovf_o  output  1  sticky return-stack overflow flag.
REQ-015 SHALL have port stk_unf_o  output  1  sticky return-stack underflow flag.

Function
REQ-016 SHALL implement the states RUN, WAIT and HALTED.
REQ-017 In RUN, SHALL update pc_o every cycle as follows: INCREMENT gives pc+1; RELATIVE gives pc+sign-extended offset_i; SUBROUTINE gives target_i; RETURN gives the popped address.
REQ-018 SHALL perform all PC arithmetic modulo 2^PC_W, so 0xFF+1 gives 0x00 and 0x02+0xFE gives 0x00 at PC_W=8.
REQ-019 On SUBROUTINE, SHALL push pc+1 (modulo 2^PC_W) onto the return stack in the same cycle.
REQ-020 On SUBROUTINE with the stack full, SHALL overwrite the oldest entry (circular buffer), keep the depth at STACK_D and set stk_ovf_o.
REQ-021 On RETURN with the stack empty, SHALL load pc_o with 0 and set stk_unf_o, leaving the depth at 0.
REQ-022 SHALL give halt_core_i priority over wfi_core_i and over mode_pc_i.
REQ-023 When halt_core_i=1 in RUN, SHALL go to HALTED with pc_o and the stack unchanged.
REQ-024 SHALL remain in HALTED until rst_i; no input other than rst_i leaves HALTED.
REQ-025 When wfi_core_i=1 and ext_int_i=0 in RUN, SHALL go to WAIT with pc_o held.
REQ-026 When wfi_core_i=1 and ext_int_i=1 in the same RUN cycle, SHALL stay in RUN and apply mode_pc_i.
REQ-027 In WAIT, SHALL hold pc_o and the stack.
REQ-028 In WAIT, SHALL leave to RUN on the first cycle with ext_int_i=1, with pc_o advancing to pc+1 on that transition.
REQ-029 In WAIT, SHALL ignore mode_pc_i, wfi_core_i and halt_core_i.
REQ-030 SHALL drive halted_o and waiting_o directly from the state register, with zero-cycle latency relative to the state.
REQ-031 Once set, SHALL hold stk_ovf_o and stk_unf_o until rst_i.

Reset
REQ-032 On rst_i=1, SHALL set pc_o=0, the state to RUN, the stack depth to 0, and halted_o, waiting_o, stk_ovf_o and stk_unf_o to 0.
REQ-033 SHALL give rst_i priority over every other input in the same cycle, including reset asserted in WAIT, in HALTED, or mid-call.
REQ-034 SHALL leave the stack storage contents unreset; only the pointer and depth are reset.

Structure
REQ-035 SHALL use the modePC enum from the shared pico package; the new pcState enum (RUN, WAIT, HALTED) SHALL also be placed in pico.
REQ-036 SHALL implement the return stack as a sub-module named ret_stack, with push/pop/full/empty signals and parameters PC_W and STACK_D.

Verification
REQ-037 Reset, then 3 cycles of INCREMENT -> pc_o sequence 0, 1, 2, 3.
REQ-038 pc_o=0x10, RELATIVE with offset_i=0xF0 -> pc_o=0x00; next cycle RELATIVE with offset_i=0x05 -> pc_o=0x05.
REQ-039 At pc_o=0x04, SUBROUTINE with target_i=0x40, then RETURN -> pc_o=0x40, then 0x05; stk_ovf_o=0 and stk_unf_o=0.
REQ-040 With STACK_D=4, five nested SUBROUTINE calls followed by five RETURNs -> stk_ovf_o=1 after the fifth call, the first four returns are correct, the fifth return gives pc_o=0x00 with stk_unf_o=1.
REQ-041 wfi_core_i=1 and ext_int_i=0 at pc_o=0x08 -> waiting_o=1 and pc_o stays 0x08 for 5 cycles; then ext_int_i=1 -> waiting_o=0 and pc_o=0x09.
REQ-042 halt_core_i=1 together with SUBROUTINE -> halted_o=1, pc_o unchanged and no push; then rst_i=1 -> pc_o=0 and halted_o=0.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared pico core package.
// Holds the next-PC mode and the PC controller state enums used by the
// decoder, the PC controller and its bench.
package pico;

    // Next-PC mode from the decoder
    typedef enum logic [1:0] {
        INCREMENT  = 2'd0,
        RELATIVE   = 2'd1,
        SUBROUTINE = 2'd2,
        RETURN     = 2'd3
    } modePC;

    // PC controller sequencing state
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } pcState;

endpackage

// File: rtl/pc_ctrl_if.sv
// Decoder <-> PC controller interface.
// master : decoder side, drives mode/offset/target/halt/wfi/interrupt,
//          observes pc and status flags.
// slave  : pc_ctrl side.
interface pc_ctrl_if #(
    parameter int PC_W = 8
);
    import pico::*;

    modePC            mode_pc_i;
    logic [PC_W-1:0]  offset_i;
    logic [PC_W-1:0]  target_i;
    logic             halt_core_i;
    logic             wfi_core_i;
    logic             ext_int_i;
    logic [PC_W-1:0]  pc_o;
    logic             halted_o;
    logic             waiting_o;
    logic             stk_ovf_o;
    logic             stk_unf_o;

    modport master (
        output mode_pc_i, offset_i, target_i, halt_core_i, wfi_core_i, ext_int_i,
        input  pc_o, halted_o, waiting_o, stk_ovf_o, stk_unf_o
    );

    modport slave (
        input  mode_pc_i, offset_i, target_i, halt_core_i, wfi_core_i, ext_int_i,
        output pc_o, halted_o, waiting_o, stk_ovf_o, stk_unf_o
    );
endinterface

// File: rtl/pc_ctrl_ret_stack.sv
// Circular return-address stack.
// Ports: clk_i/rst_i (sync, active-high), push_i/push_data_i write a new
// return address, pop_i discards the top entry, pop_data_o shows the top
// entry combinationally, full_o/empty_o report depth.
// A push while full overwrites the oldest entry. A pop while empty is
// ignored. Storage is not reset; only pointer and depth are.
module ret_stack #(
    parameter int PC_W    = 8,
    parameter int STACK_D = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_data_i,
    input  logic            pop_i,
    output logic [PC_W-1:0] pop_data_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam int PTR_W = $clog2(STACK_D);

    logic [PC_W-1:0]  mem_q [STACK_D];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   depth_q, depth_d;

    assign full_o     = (depth_q == (PTR_W+1)'(STACK_D));
    assign empty_o    = (depth_q == '0);
    // wr_ptr always points one past the top; when full it also points at
    // the oldest entry, which is what an overflowing push replaces.
    assign pop_data_o = mem_q[wr_ptr_q - PTR_W'(1)];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        depth_d  = depth_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full_o) begin
                depth_d = depth_q + (PTR_W+1)'(1);
            end
        end else if (pop_i && !empty_o) begin
            wr_ptr_d = wr_ptr_q - PTR_W'(1);
            depth_d  = depth_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            depth_q  <= depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller.
// Ports: clk_i, rst_i (sync, active-high), bus (pc_ctrl_if.slave) carrying
// the decoder's next-PC mode, branch offset, call target, halt/wfi requests,
// the external interrupt, and returning pc plus halted/waiting/overflow/
// underflow status.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | pc advances every cycle according to mode_pc_i
// WAIT   | pc and stack frozen until ext_int_i, then pc+1
// HALTED | everything frozen; only rst_i leaves
module pc_ctrl
    import pico::*;
#(
    parameter int PC_W    = 8,
    parameter int STACK_D = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    pc_ctrl_if.slave  bus
);
    pcState          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    logic            push, pop;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pop_data;
    logic            stk_full, stk_empty;

    assign pc_inc = pc_q + PC_W'(1);

    ret_stack #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D)
    ) u_ret_stack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (pc_inc),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.halt_core_i) begin
                    state_d = HALTED;
                end else if (bus.wfi_core_i && !bus.ext_int_i) begin
                    state_d = WAIT;
                end else begin
                    unique case (bus.mode_pc_i)
                        INCREMENT: pc_d = pc_inc;
                        // Plain modular add equals adding the sign-extended offset
                        RELATIVE:  pc_d = pc_q + bus.offset_i;
                        SUBROUTINE: begin
                            pc_d = bus.target_i;
                            push = 1'b1;
                            if (stk_full) begin
                                ovf_d = 1'b1;
                            end
                        end
                        RETURN: begin
                            if (stk_empty) begin
                                pc_d  = '0;
                                unf_d = 1'b1;
                            end else begin
                                pc_d = pop_data;
                                pop  = 1'b1;
                            end
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            WAIT: begin
                if (bus.ext_int_i) begin
                    state_d = RUN;
                    pc_d    = pc_inc;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.pc_o      = pc_q;
    assign bus.halted_o  = (state_q == HALTED);
    assign bus.waiting_o = (state_q == WAIT);
    assign bus.stk_ovf_o = ovf_q;
    assign bus.stk_unf_o = unf_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model built on a queue.
module tb_pc_ctrl;
    import pico::*;

    localparam int PC_W    = 8;
    localparam int STACK_D = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pc_ctrl_if #(.PC_W(PC_W)) bus ();

    pc_ctrl #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model
    logic [PC_W-1:0] m_pc;
    int              m_state;   // 0 running, 1 waiting, 2 halted
    logic [PC_W-1:0] m_stk[$];
    logic            m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst_i) begin
            m_pc = '0; m_state = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
        end else if (m_state == 0) begin
            if (bus.halt_core_i) m_state = 2;
            else if (bus.wfi_core_i && !bus.ext_int_i) m_state = 1;
            else begin
                case (bus.mode_pc_i)
                    INCREMENT: m_pc = m_pc + 8'd1;
                    RELATIVE:  m_pc = m_pc + bus.offset_i;
                    SUBROUTINE: begin
                        if (m_stk.size() == STACK_D) begin
                            void'(m_stk.pop_front());
                            m_ovf = 1;
                        end
                        m_stk.push_back(m_pc + 8'd1);
                        m_pc = bus.target_i;
                    end
                    default: begin
                        if (m_stk.size() == 0) begin
                            m_pc = '0; m_unf = 1;
                        end else m_pc = m_stk.pop_back();
                    end
                endcase
            end
        end else if (m_state == 1) begin
            if (bus.ext_int_i) begin
                m_state = 0; m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_i);
        #1;
        chk("pc",      32'(bus.pc_o),      32'(m_pc));
        chk("halted",  32'(bus.halted_o),  32'(m_state == 2));
        chk("waiting", 32'(bus.waiting_o), 32'(m_state == 1));
        chk("ovf",     32'(bus.stk_ovf_o), 32'(m_ovf));
        chk("unf",     32'(bus.stk_unf_o), 32'(m_unf));
    endtask

    task automatic drive(input modePC mode, input logic [7:0] off, input logic [7:0] tgt,
                         input logic halt, input logic wfi, input logic intr, input logic rst);
        bus.mode_pc_i   = mode;
        bus.offset_i    = off;
        bus.target_i    = tgt;
        bus.halt_core_i = halt;
        bus.wfi_core_i  = wfi;
        bus.ext_int_i   = intr;
        rst_i           = rst;
        cycle();
    endtask

    initial begin
        bus.mode_pc_i = INCREMENT; bus.offset_i = '0; bus.target_i = '0;
        bus.halt_core_i = 0; bus.wfi_core_i = 0; bus.ext_int_i = 0;
        #2;
        // Reset and increment sequence
        drive(INCREMENT, 0, 0, 0, 0, 0, 1);
        chk("reset_pc", 32'(bus.pc_o), 0);
        for (int i = 1; i <= 3; i++) begin
            drive(INCREMENT, 0, 0, 0, 0, 0, 0);
            chk("inc_seq", 32'(bus.pc_o), 32'(i));
        end
        // Relative branches with wrap
        drive(INCREMENT, 0, 0, 0, 0, 0, 1);
        drive(RELATIVE, 8'h10, 0, 0, 0, 0, 0);
        chk("rel_to10", 32'(bus.pc_o), 32'h10);
        drive(RELATIVE, 8'hF0, 0, 0, 0, 0, 0);
        chk("rel_back", 32'(bus.pc_o), 32'h00);
        drive(RELATIVE, 8'h05, 0, 0, 0, 0, 0);
        chk("rel_fwd", 32'(bus.pc_o), 32'h05);
        // Call / return
        drive(RELATIVE, 8'hFF, 0, 0, 0, 0, 0);
        chk("at04", 32'(bus.pc_o), 32'h04);
        drive(SUBROUTINE, 0, 8'h40, 0, 0, 0, 0);
        chk("call", 32'(bus.pc_o), 32'h40);
        drive(RETURN, 0, 0, 0, 0, 0, 0);
        chk("ret", 32'(bus.pc_o), 32'h05);
        chk("ret_ovf", 32'(bus.stk_ovf_o), 0);
        chk("ret_unf", 32'(bus.stk_unf_o), 0);
        // Nested calls: overflow then underflow
        drive(INCREMENT, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) drive(SUBROUTINE, 0, 8'(i * 16), 0, 0, 0, 0);
        chk("nest_ovf", 32'(bus.stk_ovf_o), 1);
        for (int i = 4; i >= 1; i--) begin
            drive(RETURN, 0, 0, 0, 0, 0, 0);
            chk("nest_ret", 32'(bus.pc_o), 32'(i * 16 + 1));
        end
        drive(RETURN, 0, 0, 0, 0, 0, 0);
        chk("unf_pc", 32'(bus.pc_o), 0);
        chk("unf_flag", 32'(bus.stk_unf_o), 1);
        // Wait for interrupt
        drive(INCREMENT, 0, 0, 0, 0, 0, 1);
        drive(RELATIVE, 8'h08, 0, 0, 0, 0, 0);
        drive(INCREMENT, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(modePC'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 0, 0);
            chk("wait_flag", 32'(bus.waiting_o), 1);
            chk("wait_pc", 32'(bus.pc_o), 32'h08);
        end
        drive(SUBROUTINE, 0, 8'h77, 1, 1, 1, 0);
        chk("wake_flag", 32'(bus.waiting_o), 0);
        chk("wake_pc", 32'(bus.pc_o), 32'h09);
        // Halt wins over a call
        drive(SUBROUTINE, 0, 8'h30, 1, 0, 0, 0);
        chk("halt_flag", 32'(bus.halted_o), 1);
        chk("halt_pc", 32'(bus.pc_o), 32'h09);
        for (int i = 0; i < 3; i++)
            drive(modePC'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 0);
        chk("halt_stay", 32'(bus.halted_o), 1);
        drive(INCREMENT, 0, 0, 0, 0, 0, 1);
        chk("halt_rst_pc", 32'(bus.pc_o), 0);
        chk("halt_rst_flag", 32'(bus.halted_o), 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(modePC'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
